// File: rtl/nway_logic_gate_if.sv
// rtl/nway_logic_gate_if.sv - control and result bundle for nway_logic_gate
//
// Purpose: groups the run/mode/input/clear controls and the gate results so
//          the gate unit and its driver connect through a single port.
// Signals (named from the gate unit's point of view):
//   i_en        1      1 = run, 0 = freeze
//   i_mode      3      0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6/7 reserved
//   i_in_vec    N_IN   input channels
//   i_clr_cnt   1      synchronous clear of o_rise_cnt
//   o_gate_raw  1      registered unfiltered reduction
//   o_gate_out  1      filtered reduction
//   o_rise_cnt  CNT_W  saturating count of o_gate_out rising edges
// Modports: master drives the controls, slave is the gate unit.
interface nway_logic_gate_if #(
  parameter int N_IN  = 3,
  parameter int CNT_W = 16
);
  logic             i_en;
  logic [2:0]       i_mode;
  logic [N_IN-1:0]  i_in_vec;
  logic             i_clr_cnt;
  logic             o_gate_raw;
  logic             o_gate_out;
  logic [CNT_W-1:0] o_rise_cnt;

  modport master (
    output i_en, i_mode, i_in_vec, i_clr_cnt,
    input  o_gate_raw, o_gate_out, o_rise_cnt
  );

  modport slave (
    input  i_en, i_mode, i_in_vec, i_clr_cnt,
    output o_gate_raw, o_gate_out, o_rise_cnt
  );
endinterface

// File: rtl/nway_logic_gate.sv
// rtl/nway_logic_gate.sv - registered N-input multi-mode logic gate with glitch filter
//
// Purpose: registers N_IN inputs, reduces them with a selectable function,
//          glitch-filters the result and counts filtered rising edges.
// Ports:
//   i_clk           clock, all state on rising edge
//   i_rst           synchronous active-high reset (overrides i_en)
//   i_selftest_sel  only with NWAY_SELFTEST_EN: 1 = internal toggle pattern feeds in_q
//   bus             nway_logic_gate_if.slave (controls in, gate results out)
// Optional feature macro: NWAY_SELFTEST_EN (adds i_selftest_sel and the pattern generator).
module nway_logic_gate #(
  parameter int N_IN     = 3,
  parameter int FILT_CYC = 4,
  parameter int CNT_W    = 16,
  parameter int STIM_DIV = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
`ifdef NWAY_SELFTEST_EN
  input  logic              i_selftest_sel,
`endif
  nway_logic_gate_if.slave  bus
);
  localparam int SW = $clog2(FILT_CYC) + 1;

  generate
    if (N_IN < 2 || FILT_CYC < 1 || CNT_W < 1 || STIM_DIV < 1) begin : g_param_check
      $fatal(1, "nway_logic_gate: illegal parameter value");
    end
  endgenerate

  logic [N_IN-1:0]  r_in_q;
  logic             r_gate_raw;
  logic             r_gate_out;
  logic [SW-1:0]    r_stab_cnt;
  logic [CNT_W-1:0] r_rise_cnt;

  logic [N_IN-1:0]  w_in_src;
  logic             w_red;
  logic             w_differs;
  logic             w_settled;
  logic             w_rise;

`ifdef NWAY_SELFTEST_EN
  // Channel k toggles every (k+1)*STIM_DIV enabled cycles; all channels start low.
  localparam int ST_W = $clog2(N_IN * STIM_DIV + 1);

  logic [N_IN-1:0]           r_st_vec;
  logic [N_IN-1:0][ST_W-1:0] r_st_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_st_vec <= '0;
      r_st_cnt <= '0;
    end else if (bus.i_en) begin
      for (int k = 0; k < N_IN; k++) begin
        if (r_st_cnt[k] == ST_W'((k + 1) * STIM_DIV - 1)) begin
          r_st_cnt[k] <= '0;
          r_st_vec[k] <= ~r_st_vec[k];
        end else begin
          r_st_cnt[k] <= r_st_cnt[k] + 1'b1;
        end
      end
    end
  end

  assign w_in_src = i_selftest_sel ? r_st_vec : bus.i_in_vec;
`else
  assign w_in_src = bus.i_in_vec;
`endif

  // Mode is applied combinationally at the gate_raw stage, so a mode change
  // simply looks like an input change to the filter.
  always_comb begin
    w_red = 1'b0;
    case (bus.i_mode)
      3'd0:    w_red =  (&r_in_q);
      3'd1:    w_red =  (|r_in_q);
      3'd2:    w_red =  (^r_in_q);
      3'd3:    w_red = ~(&r_in_q);
      3'd4:    w_red = ~(|r_in_q);
      3'd5:    w_red = ~(^r_in_q);
      default: w_red = 1'b0;
    endcase
  end

  assign w_differs = (r_gate_raw != r_gate_out);
  assign w_settled = (r_stab_cnt == SW'(FILT_CYC - 1));
  // A counted rise is exactly the enabled edge that flips gate_out from 0 to 1.
  assign w_rise    = bus.i_en && w_differs && w_settled && r_gate_raw;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_in_q     <= '0;
      r_gate_raw <= 1'b0;
      r_gate_out <= 1'b0;
      r_stab_cnt <= '0;
      r_rise_cnt <= '0;
    end else begin
      if (bus.i_en) begin
        r_in_q     <= w_in_src;
        r_gate_raw <= w_red;
        if (!w_differs) begin
          r_stab_cnt <= '0;
        end else if (w_settled) begin
          r_gate_out <= r_gate_raw;
          r_stab_cnt <= '0;
        end else begin
          r_stab_cnt <= r_stab_cnt + 1'b1;
        end
      end
      // Clear works regardless of en and beats a coincident rise.
      if (bus.i_clr_cnt) begin
        r_rise_cnt <= '0;
      end else if (w_rise && !(&r_rise_cnt)) begin
        r_rise_cnt <= r_rise_cnt + 1'b1;
      end
    end
  end

  assign bus.o_gate_raw = r_gate_raw;
  assign bus.o_gate_out = r_gate_out;
  assign bus.o_rise_cnt = r_rise_cnt;
endmodule
